// File: rtl/instruction_fetch_unit.sv
// Purpose : fetch stage; holds the PC, issues one imem request at a time, buffers the returned
//           instruction and offers it with its PC to decode; redirects discard wrong-path fetches.
// Latency : request in the first REQ cycle, instruction visible to decode the cycle after
//           imem_resp_valid; 3-cycle loop per instruction with a 1-cycle memory.
// Backpressure: decode stall holds the instruction in HOLD (stable) and no new request issues.
//
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   imem_req_valid/ready/addr       fetch request channel (addr = current PC)
//   imem_resp_valid/inst            returned instruction, single-cycle pulse, no backpressure
//   redirect_valid/pc               branch/jump target from execute (low two bits ignored)
//   ifu2idu_valid/ready/inst/pc     instruction channel to decode
module instruction_fetch_unit #(
  parameter int                    INST_WIDTH = 32,
  parameter int                    DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 64'h0000_0000_8000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [INST_WIDTH-1:0] imem_resp_inst,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  ifu2idu_valid,
  input  logic                  ifu2idu_ready,
  output logic [INST_WIDTH-1:0] ifu2idu_inst,
  output logic [DATA_WIDTH-1:0] ifu2idu_pc
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;   // address of the next/outstanding fetch
  logic [INST_WIDTH-1:0] out_inst_q, out_inst_d;   // instruction held for decode
  logic [DATA_WIDTH-1:0] out_pc_q, out_pc_d;       // PC of the held instruction
  logic                  kill_q, kill_d;           // outstanding response is wrong-path

  logic [DATA_WIDTH-1:0] redirect_tgt;

  // Targets are word aligned; the low two bits are simply cleared.
  assign redirect_tgt = redirect_pc & ~DATA_WIDTH'(3);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    out_inst_d = out_inst_q;
    out_pc_d   = out_pc_q;
    kill_d     = kill_q;

    unique case (state_q)
      S_BOOT: begin
        // Responses and redirects seen here are deliberately ignored.
        state_d = S_REQ;
      end

      S_REQ: begin
        if (redirect_valid) begin
          // Request is gated off this cycle; the target is fetched next cycle.
          fetch_pc_d = redirect_tgt;
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_tgt;
          if (imem_resp_valid) begin
            // Wrong-path response lands now: drop it, nothing left in flight.
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else begin
            // Response still to come: remember to drop it.
            kill_d = 1'b1;
          end
        end else if (imem_resp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            out_inst_d = imem_resp_inst;
            out_pc_d   = fetch_pc_q;
            state_d    = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (redirect_valid) begin
          // Held instruction is discarded; a same-cycle ready is not a handshake.
          fetch_pc_d = redirect_tgt;
          state_d    = S_REQ;
        end else if (ifu2idu_ready) begin
          fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
          state_d    = S_REQ;
        end
      end

      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      fetch_pc_q <= RESET_PC;
      out_inst_q <= '0;
      out_pc_q   <= '0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_inst_q <= out_inst_d;
      out_pc_q   <= out_pc_d;
      kill_q     <= kill_d;
    end
  end

  // Redirect gates both valids combinationally so no wrong-path transfer completes.
  assign imem_req_valid = (state_q == S_REQ) && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign ifu2idu_valid  = (state_q == S_HOLD) && !redirect_valid;
  assign ifu2idu_inst   = out_inst_q;
  assign ifu2idu_pc     = out_pc_q;

endmodule
